// File: rtl/gx4000_printer_ctrl.sv
// Centronics printer port sequencer: 4-entry byte FIFO feeding a setup/strobe/hold/ack engine,
// with busy/ack synchronizers and a registered CPU status byte.
module gx4000_printer_ctrl #(
    parameter int unsigned SETUP_CYC   = 16,
    parameter int unsigned STROBE_CYC  = 32,
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_data_stb,
    input  logic [7:0] wr_data,
    input  logic       wr_ctrl_stb,
    input  logic [7:0] wr_ctrl,
    output logic [7:0] status,
    output logic [7:0] printer_data,
    output logic       printer_strobe,
    input  logic       printer_busy,
    input  logic       printer_ack
);

    localparam logic [15:0] SETUP_LD   = 16'(SETUP_CYC - 1);
    localparam logic [15:0] STROBE_LD  = 16'(STROBE_CYC - 1);
    localparam logic [15:0] HOLD_LD    = 16'(HOLD_CYC - 1);
    localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StWaitAck
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];
    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [2:0]  level_q, level_d;
    logic        tout_q, tout_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  pdata_q, pdata_d;
    logic [7:0]  status_q, status_d;

    logic busy_s1_q, busy_s2_q;
    logic ack_s1_q, ack_s2_q, ack_s3_q;

    logic flush, clr, wr_req, full, wr_ok, ovf_set, can_pop, ack_rise, tout_set;

    logic unused_ctrl;
    assign unused_ctrl = ^wr_ctrl[7:2];

    assign flush    = wr_ctrl_stb & wr_ctrl[0];
    assign clr      = wr_ctrl_stb & wr_ctrl[1];
    assign wr_req   = wr_data_stb & enable;
    assign full     = (level_q == 3'd4);
    // A flush empties the FIFO first, so a same-cycle write always lands.
    assign wr_ok    = wr_req & (flush | ~full);
    assign ovf_set  = wr_req & ~flush & full;
    assign can_pop  = (state_q == StIdle) & enable & (level_q != 3'd0) & ~busy_s2_q & ~tout_q
                      & ~flush;
    assign ack_rise = ack_s2_q & ~ack_s3_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pdata_d  = pdata_q;
        tout_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (can_pop) begin
                    pdata_d = mem_q[head_q];
                    cnt_d   = SETUP_LD;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = STROBE_LD;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StStrobe: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = HOLD_LD;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StHold: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = TIMEOUT_LD;
                    state_d = StWaitAck;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StWaitAck: begin
                if (ack_rise) begin
                    state_d = StIdle;
                end else if (cnt_q == 16'd0) begin
                    tout_set = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (flush) begin
            head_d  = 2'd0;
            tail_d  = 2'd0;
            level_d = 3'd0;
            if (wr_ok) begin
                mem_d[0] = wr_data;
                tail_d   = 2'd1;
                level_d  = 3'd1;
            end
        end else begin
            if (can_pop) begin
                head_d = head_q + 2'd1;
            end
            if (wr_ok) begin
                mem_d[tail_q] = wr_data;
                tail_d        = tail_q + 2'd1;
            end
            level_d = level_q + {2'b00, wr_ok} - {2'b00, can_pop};
        end
    end

    // An error set in the same cycle as a clear wins.
    always_comb begin
        tout_d   = (tout_q & ~clr) | tout_set;
        ovf_d    = (ovf_q & ~clr) | ovf_set;
        status_d = {level_q, ovf_q, tout_q, (state_q != StIdle), full, (level_q == 3'd0)};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 16'd0;
            mem_q     <= '{default: 8'h00};
            head_q    <= 2'd0;
            tail_q    <= 2'd0;
            level_q   <= 3'd0;
            tout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            pdata_q   <= 8'h00;
            status_q  <= 8'h01;
            busy_s1_q <= 1'b0;
            busy_s2_q <= 1'b0;
            ack_s1_q  <= 1'b0;
            ack_s2_q  <= 1'b0;
            ack_s3_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_q     <= mem_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            level_q   <= level_d;
            tout_q    <= tout_d;
            ovf_q     <= ovf_d;
            pdata_q   <= pdata_d;
            status_q  <= status_d;
            busy_s1_q <= printer_busy;
            busy_s2_q <= busy_s1_q;
            ack_s1_q  <= printer_ack;
            ack_s2_q  <= ack_s1_q;
            ack_s3_q  <= ack_s2_q;
        end
    end

    assign status         = status_q;
    assign printer_data   = pdata_q;
    assign printer_strobe = (state_q == StStrobe);

endmodule

// File: tb/tb_gx4000_printer_ctrl.sv
// Bench for gx4000_printer_ctrl: cycle-exact vector table for one byte, directed corner
// sequences, and randomized bursts checked against a capacity-4 queue model.
module tb_gx4000_printer_ctrl;

    localparam int unsigned SETUP   = 2;
    localparam int unsigned STROBE  = 4;
    localparam int unsigned HOLD    = 2;
    localparam int unsigned TIMEOUT = 64;

    logic       clk_sys = 1'b0;
    logic       reset, enable, wr_data_stb, wr_ctrl_stb, printer_busy;
    logic [7:0] wr_data, wr_ctrl;
    logic [7:0] status, printer_data;
    logic       printer_strobe, printer_ack;
    logic       ack_auto = 1'b0;
    logic       ack_man  = 1'b0;

    assign printer_ack = ack_auto | ack_man;

    gx4000_printer_ctrl #(
        .SETUP_CYC  (SETUP),
        .STROBE_CYC (STROBE),
        .HOLD_CYC   (HOLD),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .enable        (enable),
        .wr_data_stb   (wr_data_stb),
        .wr_data       (wr_data),
        .wr_ctrl_stb   (wr_ctrl_stb),
        .wr_ctrl       (wr_ctrl),
        .status        (status),
        .printer_data  (printer_data),
        .printer_strobe(printer_strobe),
        .printer_busy  (printer_busy),
        .printer_ack   (printer_ack)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_data_stb = 1'b1;
        wr_data     = b;
        tick();
        wr_data_stb = 1'b0;
    endtask

    task automatic ctrl(input logic [7:0] v);
        wr_ctrl_stb = 1'b1;
        wr_ctrl     = v;
        tick();
        wr_ctrl_stb = 1'b0;
    endtask

    // Printer-side monitor: captures each byte at strobe rise, checks width and hold.
    logic [7:0] seen_q[$];
    logic       mon_en   = 1'b1;
    logic       mon_prev = 1'b0;
    int         mon_w    = 0;
    logic [7:0] mon_cap  = 8'h00;

    initial forever begin
        @(negedge clk_sys);
        if (printer_strobe && !mon_prev) begin
            seen_q.push_back(printer_data);
            mon_w   = 1;
            mon_cap = printer_data;
        end else if (printer_strobe) begin
            mon_w++;
        end else if (mon_prev && mon_en) begin
            check("strobe_width", mon_w, STROBE);
            check("data_hold", printer_data, mon_cap);
        end
        mon_prev = printer_strobe;
    end

    // Printer-side responder: pulses ack a random delay after each strobe fall.
    logic resp_en   = 1'b0;
    logic resp_prev = 1'b0;

    initial forever begin
        @(negedge clk_sys);
        if (resp_en && resp_prev && !printer_strobe) begin
            repeat ($urandom_range(8, 2)) @(posedge clk_sys);
            #1 ack_auto = 1'b1;
            repeat (3) @(posedge clk_sys);
            #1 ack_auto = 1'b0;
        end
        resp_prev = printer_strobe;
    end

    task automatic wait_seen(input int n, input int budget, input string name);
        int c = 0;
        while (seen_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        if (seen_q.size() < n) begin
            n_checks++;
            $display("FAIL %s: timed out, got %0d bytes, expected %0d", name, seen_q.size(), n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int         k;
        logic       chk_data;
        logic       exp_strobe;
        logic [7:0] exp_data;
        logic       chk_status;
        logic [7:0] exp_status;
    } vec_t;

    vec_t vecs[10];

    function automatic int exp_status(input int lvl, input logic ovf, input logic tout,
                                      input logic active);
        return (lvl << 5) | (int'(ovf) << 4) | (int'(tout) << 3) | (int'(active) << 2)
               | (int'(lvl == 4) << 1) | int'(lvl == 0);
    endfunction

    initial begin
        logic [7:0] exp_q[$];
        logic       exp_ovf;
        int         c;

        // Cycle k relative to the write pulse at k=0; ack pin high for k=14..17.
        vecs[0] = '{1,  1'b0, 1'b0, 8'h00, 1'b1, 8'h01};
        vecs[1] = '{2,  1'b1, 1'b0, 8'hA5, 1'b1, 8'h20};
        vecs[2] = '{3,  1'b1, 1'b0, 8'hA5, 1'b1, 8'h05};
        vecs[3] = '{4,  1'b1, 1'b1, 8'hA5, 1'b1, 8'h05};
        vecs[4] = '{7,  1'b1, 1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[5] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 8'h00};
        vecs[6] = '{12, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h05};
        vecs[7] = '{17, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h05};
        vecs[8] = '{18, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h01};
        vecs[9] = '{19, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h01};

        reset = 1'b1; enable = 1'b1; wr_data_stb = 1'b0; wr_data = 8'h00;
        wr_ctrl_stb = 1'b0; wr_ctrl = 8'h00; printer_busy = 1'b0;
        repeat (4) tick();
        check("rst_status", status, 8'h01);
        check("rst_strobe", printer_strobe, 0);
        check("rst_data", printer_data, 8'h00);
        reset = 1'b0;
        repeat (4) tick();

        // Single byte, cycle-exact.
        seen_q.delete();
        for (int cy = 0; cy < 20; cy++) begin
            wr_data_stb = (cy == 0);
            wr_data     = 8'hA5;
            ack_man     = (cy >= 14 && cy <= 17);
            @(negedge clk_sys);
            for (int i = 0; i < 10; i++) begin
                if (vecs[i].k == cy) begin
                    check($sformatf("vec%0d_strobe", cy), printer_strobe, vecs[i].exp_strobe);
                    if (vecs[i].chk_data)
                        check($sformatf("vec%0d_data", cy), printer_data, vecs[i].exp_data);
                    if (vecs[i].chk_status)
                        check($sformatf("vec%0d_status", cy), status, vecs[i].exp_status);
                end
            end
            @(posedge clk_sys);
            #1;
        end
        wr_data_stb = 1'b0;
        ack_man     = 1'b0;
        repeat (5) tick();

        // Fill and overflow under busy.
        seen_q.delete();
        printer_busy = 1'b1;
        repeat (3) tick();
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); wr_byte(8'h44); wr_byte(8'h55);
        tick();
        check("full_status", status, 8'h92);
        resp_en      = 1'b1;
        printer_busy = 1'b0;
        wait_seen(4, 400, "fill_drain");
        repeat (50) tick();
        check("fill_count", seen_q.size(), 4);
        if (seen_q.size() >= 4) begin
            check("fill_b0", seen_q[0], 8'h11);
            check("fill_b1", seen_q[1], 8'h22);
            check("fill_b2", seen_q[2], 8'h33);
            check("fill_b3", seen_q[3], 8'h44);
        end
        check("ovf_sticky", status, 8'h11);
        ctrl(8'h02);
        tick();
        check("ovf_cleared", status, 8'h01);

        // Ack timeout blocks dispatch until errors are cleared.
        resp_en = 1'b0;
        seen_q.delete();
        wr_byte(8'h7E);
        wr_byte(8'h3C);
        repeat (72) tick();
        check("tout_before", status, 8'h24);
        tick();
        check("tout_set", status, 8'h28);
        repeat (20) tick();
        check("tout_blocked_count", seen_q.size(), 1);
        if (seen_q.size() >= 1) check("tout_byte", seen_q[0], 8'h7E);
        check("tout_held", status, 8'h28);
        resp_en = 1'b1;
        ctrl(8'h02);
        wait_seen(2, 200, "tout_resume");
        if (seen_q.size() >= 2) check("tout_next", seen_q[1], 8'h3C);
        repeat (40) tick();
        check("tout_idle", status, 8'h01);

        // Flush combined with a write.
        resp_en = 1'b0;
        printer_busy = 1'b1;
        repeat (3) tick();
        seen_q.delete();
        wr_byte(8'hA1); wr_byte(8'hA2); wr_byte(8'hA3);
        wr_data_stb = 1'b1; wr_data = 8'h99; wr_ctrl_stb = 1'b1; wr_ctrl = 8'h01;
        tick();
        wr_data_stb = 1'b0; wr_ctrl_stb = 1'b0;
        tick();
        check("flush_status", status, 8'h20);
        resp_en      = 1'b1;
        printer_busy = 1'b0;
        wait_seen(1, 200, "flush_drain");
        repeat (50) tick();
        check("flush_count", seen_q.size(), 1);
        if (seen_q.size() >= 1) check("flush_byte", seen_q[0], 8'h99);
        check("flush_idle", status, 8'h01);

        // Reset in the middle of the strobe.
        resp_en = 1'b0;
        mon_en  = 1'b0;
        wr_byte(8'h5A);
        c = 0;
        while (!printer_strobe && c < 20) begin
            tick();
            c++;
        end
        check("rst_mid_reached_strobe", printer_strobe, 1);
        reset = 1'b1;
        tick();
        check("rst_mid_strobe", printer_strobe, 0);
        check("rst_mid_data", printer_data, 8'h00);
        check("rst_mid_status", status, 8'h01);
        reset = 1'b0;
        repeat (3) tick();
        ack_man = 1'b1;
        repeat (4) tick();
        ack_man = 1'b0;
        repeat (6) tick();
        check("post_rst_status", status, 8'h01);
        check("post_rst_strobe", printer_strobe, 0);
        check("post_rst_data", printer_data, 8'h00);
        mon_en = 1'b1;

        // Randomized bursts against a capacity-4 queue model.
        resp_en = 1'b1;
        for (int it = 0; it < 12; it++) begin
            printer_busy = 1'b1;
            repeat (3) tick();
            seen_q.delete();
            exp_q.delete();
            exp_ovf = 1'b0;
            for (int j = 0; j < int'($urandom_range(6, 1)); j++) begin
                logic [7:0] b;
                logic       en;
                b      = 8'($urandom);
                en     = ($urandom_range(4, 0) != 0);
                enable = en;
                wr_byte(b);
                if (en) begin
                    if (exp_q.size() < 4) exp_q.push_back(b);
                    else exp_ovf = 1'b1;
                end
                repeat ($urandom_range(2, 0)) tick();
            end
            enable = 1'b1;
            tick();
            check($sformatf("rnd%0d_status_q", it), status,
                  exp_status(exp_q.size(), exp_ovf, 1'b0, 1'b0));
            printer_busy = 1'b0;
            if (exp_q.size() > 0) wait_seen(exp_q.size(), 100 * exp_q.size() + 50, "rnd_drain");
            repeat (50) tick();
            check($sformatf("rnd%0d_count", it), seen_q.size(), exp_q.size());
            for (int j = 0; j < exp_q.size() && j < seen_q.size(); j++)
                check($sformatf("rnd%0d_b%0d", it, j), seen_q[j], exp_q[j]);
            check($sformatf("rnd%0d_status_end", it), status,
                  exp_status(0, exp_ovf, 1'b0, 1'b0));
            ctrl(8'h02);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
